// File: rtl/inv_mix_columns.sv
// inv_mix_columns: byte-serial AES InvMixColumns stage for the decryption datapath.
// Collects a 16-byte state (index k = 4*row + col), applies the inverse MixColumns
// matrix to each column over GF(2^8), then streams the 16 result bytes out. A block whose
// first byte arrives with rowNo == BYPASS_ROUND is forwarded unchanged (final round).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   din[7:0]   in   state byte
//   en         in   din/rowNo valid
//   rowNo[7:0] in   round number, sampled on the first byte of a block
//   dout[7:0]  out  result byte (registered)
//   enable_out out  dout valid (registered)
//   busy       out  block in COMPUTE or OUTPUT; en ignored while high
module inv_mix_columns #(
    parameter int unsigned BYPASS_ROUND  = 9,
    parameter int unsigned MAX_MIX_ROUND = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       en,
    input  logic [7:0] rowNo,
    output logic [7:0] dout,
    output logic       enable_out,
    output logic       busy
);

    typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;      // bytes accepted in the current block
    logic [1:0]  col_q;      // column being transformed in COMPUTE
    logic [3:0]  oidx_q;     // next byte to emit in OUTPUT
    logic        mix_q;      // 1: inverse-mix block, 0: bypass block
    logic [7:0]  buf_q [16];

    logic        row_mix;
    logic        row_bypass;
    logic        accept;
    logic        last_in;
    logic [7:0]  res [4];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    assign row_mix    = (rowNo <= 8'(MAX_MIX_ROUND));
    assign row_bypass = (rowNo == 8'(BYPASS_ROUND));
    // The first byte of a block is only taken when its rowNo selects a mode.
    assign accept     = (state_q == StLoad) && en && ((cnt_q != 4'd0) || row_mix || row_bypass);
    assign last_in    = accept && (cnt_q == 4'd15);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:    if (last_in) state_d = mix_q ? StCompute : StOutput;
            StCompute: if (col_q == 2'd3) state_d = StOutput;
            StOutput:  if (oidx_q == 4'd15) state_d = StLoad;
            default:   state_d = StLoad;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q != StLoad);
    end

    // Column transform for the column selected by col_q, built from chained xtime.
    always_comb begin
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = buf_q[{2'(r), col_q}];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        res[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        res[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        res[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        res[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end

    // Control counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            col_q      <= 2'd0;
            oidx_q     <= 4'd0;
            mix_q      <= 1'b0;
            dout       <= 8'h00;
            enable_out <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    enable_out <= 1'b0;
                    if (accept) begin
                        cnt_q <= cnt_q + 4'd1;  // wraps to 0 after byte 15
                        if (cnt_q == 4'd0) mix_q <= row_mix;
                    end
                end
                StCompute: begin
                    col_q <= col_q + 2'd1;
                end
                StOutput: begin
                    enable_out <= 1'b1;
                    dout       <= buf_q[oidx_q];
                    oidx_q     <= oidx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Block buffer: filled in LOAD, rewritten in place one column per COMPUTE cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[cnt_q] <= din;
        end else if (state_q == StCompute) begin
            for (int r = 0; r < 4; r++) begin
                buf_q[{2'(r), col_q}] <= res[r];
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
module tb_inv_mix_columns;

    typedef logic [7:0] blk_t [16];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] rowNo = 8'h00;
    logic [7:0] dout;
    logic       enable_out;
    logic       busy;

    always #5 clk = ~clk;

    inv_mix_columns #(
        .BYPASS_ROUND (9),
        .MAX_MIX_ROUND(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .en        (en),
        .rowNo     (rowNo),
        .dout      (dout),
        .enable_out(enable_out),
        .busy      (busy)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q[$];
    int unsigned lat_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Generic GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Inverse MixColumns as a circulant matrix product on each column.
    function automatic blk_t inv_mix_ref(input blk_t s);
        logic [7:0] coef [4];
        blk_t o;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o[4*r+c] = 8'h00;
                for (int j = 0; j < 4; j++) o[4*r+c] ^= gmul(coef[(j-r+4)%4], s[4*j+c]);
            end
        return o;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a byte.
    logic [7:0] last_exp = 8'h00;
    initial begin
        bit prev_en = 0;
        int run_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 0;
                run_len = 0;
            end else begin
                if (enable_out) begin
                    if (!prev_en) begin
                        if (lat_q.size() == 0) fail("unexpected_burst");
                        else chk("first_out_edge", cyc, lat_q.pop_front());
                    end
                    if (exp_q.size() == 0) begin
                        fail("extra_output");
                    end else begin
                        last_exp = exp_q.pop_front();
                        chk("dout", dout, last_exp);
                    end
                    run_len++;
                end else if (prev_en) begin
                    chk("burst_len", run_len, 16);
                    chk("dout_hold", dout, last_exp);
                    run_len = 0;
                end
                prev_en = enable_out;
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b, input logic [7:0] row);
        en = 1'b1;
        din = b;
        rowNo = row;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Sends a block; leaves the bench at the negedge after the edge taking byte 15.
    task automatic send_block(input blk_t blk, input logic [7:0] row, input int gap_max,
                              input bit use_ref);
        blk_t res;
        res = (row <= 8) ? inv_mix_ref(blk) : blk;
        if (use_ref) for (int i = 0; i < 16; i++) exp_q.push_back(res[i]);
        for (int i = 0; i < 16; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    en = 1'b0;
                    din = 8'($urandom);
                    rowNo = 8'($urandom);
                    @(negedge clk);
                end
            end
            drive_byte(blk[i], (i == 0) ? row : 8'($urandom));
        end
        lat_q.push_back(cyc + ((row <= 8) ? 5 : 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0 || busy || enable_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("drain_timeout");
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_enable_out", enable_out, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", busy, 0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        blk_t b;
        logic [7:0] kin  [16] = '{8'h8e, 8'h9f, 8'h01, 8'hc6, 8'h4d, 8'hdc, 8'h01, 8'hc6,
                                  8'ha1, 8'h58, 8'h01, 8'hc6, 8'hbc, 8'h9d, 8'h01, 8'hc6};
        logic [7:0] kout [16] = '{8'hdb, 8'hf2, 8'h01, 8'hc6, 8'h13, 8'h0a, 8'h01, 8'hc6,
                                  8'h53, 8'h22, 8'h01, 8'hc6, 8'h45, 8'h5c, 8'h01, 8'hc6};
        int n;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset_enable_out", enable_out, 0);
        chk("reset_dout", dout, 8'h00);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Known-answer MIX block
        for (int i = 0; i < 16; i++) begin
            b[i] = kin[i];
            exp_q.push_back(kout[i]);
        end
        send_block(b, 8'd3, 0, 0);
        drain();

        // BYPASS with identity bytes
        for (int i = 0; i < 16; i++) b[i] = 8'(i);
        send_block(b, 8'd9, 0, 1);
        drain();

        // All-zero block with random en gaps
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        send_block(b, 8'd5, 3, 1);
        drain();

        // Rejected first byte (rowNo above bypass), then a full block
        drive_byte(8'h55, 8'd10);
        drive_byte(8'h66, 8'd200);
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd0, 0, 1);
        drain();

        // Busy drop: ff bytes during COMPUTE/OUTPUT, then the repeated-column block
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd8, 0, 1);
        for (int i = 0; i < 8; i++) begin
            chk("busy_during_drop", busy, 1);
            drive_byte(8'hff, 8'd3);
        end
        drain();
        for (int i = 0; i < 16; i++) begin
            case (i / 4)
                0: b[i] = 8'h2d;
                1: b[i] = 8'h26;
                2: b[i] = 8'h31;
                default: b[i] = 8'h4c;
            endcase
        end
        send_block(b, 8'd1, 0, 1);
        drain();

        // Randomized blocks, random rounds 0..9, random gaps
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
            send_block(b, 8'($urandom_range(0, 9)), (k % 2) ? 2 : 0, 1);
            drain();
        end

        // Reset after output byte 6
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd4, 0, 1);
        repeat (11) @(negedge clk);
        pulse_reset();
        repeat (3) begin
            @(negedge clk);
            chk("no_output_after_reset", enable_out, 0);
        end

        // Reset after input byte 9, then a fresh block
        for (int i = 0; i < 10; i++) drive_byte(8'($urandom), 8'd2);
        pulse_reset();
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd2, 0, 1);
        drain();

        // Back-to-back: MIX then BYPASS starting the first cycle busy is low
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd7, 0, 1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("busy_timeout");
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_block(b, 8'd9, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
